// File: rtl/alu_mdu.sv
// RV32 execute unit: registered base ALU plus iterative M-extension (shift-add mul, restoring div).
// Latency: base ops 1 cycle, fully pipelined; M ops XLEN+1 cycles, independent of data.
// Backpressure: ready_o drops while an M op iterates; valid_i is ignored until it returns.
module alu_mdu #(
    parameter int  XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [4:0]      funct_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            valid_o,
    output logic [XLEN-1:0] rd_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t              state_q, state_d;
    logic [SHW-1:0]      cnt_q;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opm_q;
    logic [2:0]          f3_q;
    logic                sa_q, sb_q, div_zero_q;

    logic                accept, base_go, m_go, last;
    logic [2:0]          f3_in;
    logic                sa_in, sb_in;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [SHW-1:0]      shamt;
    logic [XLEN-1:0]     alu_res, m_res;

    assign ready_o = (state_q == S_IDLE);
    assign accept  = valid_i && ready_o;
    assign base_go = accept && !funct_i[4];
    assign m_go    = accept && funct_i[4];
    assign last    = (cnt_q == SHW'(XLEN - 1));
    assign shamt   = rs2_i[SHW-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (m_go) state_d = funct_i[2] ? S_DIV : S_MUL;
            S_MUL, S_DIV: if (last) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (funct_i[3:0])
            4'b0000: alu_res = rs1_i + rs2_i;
            4'b1000: alu_res = rs1_i - rs2_i;
            4'b0001: alu_res = rs1_i << shamt;
            4'b0101: alu_res = rs1_i >> shamt;
            4'b1101: alu_res = $signed(rs1_i) >>> shamt;
            4'b0010: alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_i) < $signed(rs2_i))};
            4'b0011: alu_res = {{(XLEN-1){1'b0}}, (rs1_i < rs2_i)};
            4'b0100: alu_res = rs1_i ^ rs2_i;
            4'b0110: alu_res = rs1_i | rs2_i;
            4'b0111: alu_res = rs1_i & rs2_i;
            default: alu_res = '0;
        endcase
    end

    // Datapath iterates on magnitudes; signs are restored on the final step.
    assign f3_in = funct_i[2:0];
    assign sa_in = rs1_i[XLEN-1] && (f3_in == 3'b001 || f3_in == 3'b010 ||
                                     f3_in == 3'b100 || f3_in == 3'b110);
    assign sb_in = rs2_i[XLEN-1] && (f3_in == 3'b001 || f3_in == 3'b100 || f3_in == 3'b110);
    assign a_mag = sa_in ? -rs1_i : rs1_i;
    assign b_mag = sb_in ? -rs2_i : rs2_i;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] q_res, r_res, neg_hi;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opm_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opm_q});
        div_rem   = div_ge ? (div_shift[XLEN-1:0] - opm_q) : div_shift[XLEN-1:0];
        if (state_q == S_DIV) begin
            acc_d = {div_rem, acc_q[XLEN-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // High half of the negated product: ~hi plus the carry out of negating lo.
    assign neg_hi = ~acc_d[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, (acc_d[XLEN-1:0] == '0)};
    assign q_res  = acc_d[XLEN-1:0];
    assign r_res  = acc_d[2*XLEN-1:XLEN];

    always_comb begin
        m_res = '0;
        case (f3_q)
            3'b000:                 m_res = q_res;
            3'b001, 3'b010, 3'b011: m_res = (sa_q ^ sb_q) ? neg_hi : r_res;
            3'b100:                 m_res = div_zero_q ? '1 : ((sa_q ^ sb_q) ? -q_res : q_res);
            3'b101:                 m_res = div_zero_q ? '1 : q_res;
            3'b110:                 m_res = sa_q ? -r_res : r_res;
            3'b111:                 m_res = r_res;
            default:                m_res = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            opm_q      <= '0;
            f3_q       <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            div_zero_q <= 1'b0;
            valid_o    <= 1'b0;
            rd_o       <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (base_go) begin
                        rd_o    <= alu_res;
                        valid_o <= 1'b1;
                    end else if (m_go) begin
                        f3_q       <= f3_in;
                        sa_q       <= sa_in;
                        sb_q       <= sb_in;
                        div_zero_q <= (rs2_i == '0);
                        cnt_q      <= '0;
                        acc_q      <= {{XLEN{1'b0}}, (funct_i[2] ? a_mag : b_mag)};
                        opm_q      <= funct_i[2] ? b_mag : a_mag;
                    end
                end
                default: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + SHW'(1);
                    if (last) begin
                        rd_o    <= m_res;
                        valid_o <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboarded bench for alu_mdu: directed spec vectors plus random ops against an arithmetic model.
module tb_alu_mdu;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  funct;
    logic [31:0] rs1, rs2;
    logic        ready_o, valid_o;
    logic [31:0] rd_o;

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .funct_i (funct),
        .rs1_i   (rs1),
        .rs2_i   (rs2),
        .valid_o (valid_o),
        .rd_o    (rd_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb_v, ua, ub;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        ua   = longint'({32'd0, a});
        ub   = longint'({32'd0, b});
        if (!f[4]) begin
            case (f[3:0])
                4'b0000: return a + b;
                4'b1000: return a - b;
                4'b0001: return a << b[4:0];
                4'b0101: return a >> b[4:0];
                4'b1101: return 32'($signed(a) >>> b[4:0]);
                4'b0010: return (sa < sb_v) ? 32'd1 : 32'd0;
                4'b0011: return (a < b) ? 32'd1 : 32'd0;
                4'b0100: return a ^ b;
                4'b0110: return a | b;
                4'b0111: return a & b;
                default: return 32'd0;
            endcase
        end
        case (f[2:0])
            3'd0: begin p = 64'(sa * sb_v); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb_v); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub);   return p[63:32]; end
            3'd3: begin p = 64'(ua * ub);   return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb_v);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb_v);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Presented request is accepted on the next edge once ready_o is seen high.
    task automatic send_exp(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        int w;
        w = 0;
        funct   = f;
        rs1     = a;
        rs2     = b;
        valid_i = 1'b1;
        @(negedge clk);
        while (!ready_o && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!ready_o) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: ready_o=%b, required 1 within 100 cycles", ready_o);
        end else begin
            sb.push_back('{exp, cyc + (f[4] ? XLEN + 1 : 1)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        send_exp(f, a, b, model(f, a, b));
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] rand_funct();
        logic [3:0] codes [11];
        codes = '{4'b0000, 4'b1000, 4'b0001, 4'b0101, 4'b1101, 4'b0010,
                  4'b0011, 4'b0100, 4'b0110, 4'b0111, 4'b1001};
        if ($urandom_range(0, 1) == 0) return {1'b0, codes[$urandom_range(0, 10)]};
        return {2'b10, 3'($urandom_range(0, 7))};
    endfunction

    // Monitor: result/latency against the scoreboard, rd_o hold, busy window length.
    logic [31:0] prev_rd;
    int          run;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            run     = 0;
            prev_rd = 32'd0;
        end else begin
            if (valid_o) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_valid: valid_o=1 with no request outstanding, rd_o=%h", rd_o);
                end else begin
                    e = sb.pop_front();
                    chk("rd_o", rd_o, e.val);
                    chk("result_cycle", cyc, e.at);
                end
            end else begin
                chk("rd_hold", rd_o, prev_rd);
            end
            prev_rd = rd_o;
            if (!ready_o) begin
                run++;
            end else begin
                if (run > 0) chk("busy_cycles", run, XLEN);
                run = 0;
            end
        end
    end

    initial begin
        int w;
        rst     = 1'b1;
        valid_i = 1'b0;
        funct   = 5'd0;
        rs1     = 32'd0;
        rs2     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", ready_o, 1);
        chk("reset_valid", valid_o, 0);
        chk("reset_rd", rd_o, 0);
        @(posedge clk);
        #1;

        send_exp(5'b00000, 32'd5, 32'd7, 32'h0000_000C);
        send_exp(5'b01000, 32'd3, 32'd5, 32'hFFFF_FFFE);
        send_exp(5'b01101, 32'h8000_0000, 32'h24, 32'hF800_0000);
        send_exp(5'b00011, 32'd1, 32'hFFFF_FFFF, 32'd1);
        send_exp(5'b00010, 32'd1, 32'hFFFF_FFFF, 32'd0);
        send_exp(5'b01001, 32'd1, 32'd2, 32'd0);
        idle(2);

        send_exp(5'b10000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
        send_exp(5'b10001, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF);
        send_exp(5'b10011, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006);
        send_exp(5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        send_exp(5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        send_exp(5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        send_exp(5'b10101, 32'd7, 32'd0, 32'hFFFF_FFFF);
        send_exp(5'b10111, 32'd7, 32'd0, 32'd7);
        send_exp(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        send_exp(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        send_exp(5'b10100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        send_exp(5'b10110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        idle(3);

        // Busy div with valid_i held and inputs churning; next request lands in the result cycle.
        send_exp(5'b10100, 32'd100, 32'd7, 32'd14);
        w = 0;
        while (w < 100) begin
            funct   = rand_funct();
            rs1     = rand_opnd();
            rs2     = rand_opnd();
            valid_i = 1'b1;
            @(negedge clk);
            if (ready_o) begin
                sb.push_back('{model(funct, rs1, rs2), cyc + (funct[4] ? XLEN + 1 : 1)});
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            w++;
        end
        chk("churn_accept_bound", (w < 100), 1);
        idle(40);

        // Reset lands mid-multiply: the pending result must never appear.
        send(5'b10000, 32'd1234, 32'd5678);
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", ready_o, 1);
        chk("abort_valid", valid_o, 0);
        chk("abort_rd", rd_o, 0);
        @(posedge clk);
        #1;
        idle(30);
        send_exp(5'b00000, 32'd1, 32'd1, 32'd2);
        idle(2);

        for (int i = 0; i < 300; i++) begin
            send(rand_funct(), rand_opnd(), rand_opnd());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        valid_i = 1'b0;

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        repeat (2) @(posedge clk);
        chk("drain_outstanding", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
